riscboy_ppu_blender: RTL and testbench

RISCBOY_PPU_BLENDER -- requirements
Module: riscboy_ppu_blender

---
 rtl/riscboy_ppu_blender.sv | 116 +++++++++++
 tb/tb_riscboy_ppu_blender.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/riscboy_ppu_blender.sv
// Two-layer scanline pixel blender: picks the highest-priority opaque layer
// (or the backdrop) and queues {colour, x} in a 2-entry output FIFO.
module riscboy_ppu_blender #(
  parameter int W_PIXDATA = 15,
  parameter int W_COORD   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           en_layer,
  input  logic                 flush,
  input  logic                 in0_vld,
  output logic                 in0_rdy,
  input  logic                 in0_alpha,
  input  logic [W_PIXDATA-1:0] in0_pixdata,
  input  logic                 in1_vld,
  output logic                 in1_rdy,
  input  logic                 in1_alpha,
  input  logic [W_PIXDATA-1:0] in1_pixdata,
  input  logic [W_PIXDATA-1:0] cfg_backdrop,
  input  logic [W_COORD-1:0]   cfg_last_x,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [W_PIXDATA-1:0] out_pixdata,
  output logic [W_COORD-1:0]   out_x,
  output logic                 line_done
);

  typedef enum logic [0:0] {
    ACTIVE = 1'b0,
    DONE   = 1'b1
  } state_t;

  state_t               state;
  logic [W_COORD-1:0]   x;
  logic [1:0]           count;
  logic [W_PIXDATA-1:0] tail_pixdata;
  logic [W_COORD-1:0]   tail_x;
  logic                 layers_vld;
  logic                 fire;
  logic                 pop;
  logic [W_PIXDATA-1:0] comp_pixdata;

  // A disabled layer never stalls compositing; its valid is ignored.
  assign layers_vld = (in0_vld || !en_layer[0]) && (in1_vld || !en_layer[1]);
  // Space check uses the registered count only, so out_rdy never reaches the rdys.
  assign fire = !rst && (state == ACTIVE) && !flush && (count != 2'd2) && layers_vld;

  assign in0_rdy   = fire && en_layer[0];
  assign in1_rdy   = fire && en_layer[1];
  assign out_vld   = (count != 2'd0);
  assign pop       = out_vld && out_rdy && !rst;
  assign line_done = pop && (out_x == cfg_last_x);

  always_comb begin
    comp_pixdata = cfg_backdrop;
    if (en_layer[0] && in0_alpha) begin
      comp_pixdata = in0_pixdata;
    end else if (en_layer[1] && in1_alpha) begin
      comp_pixdata = in1_pixdata;
    end else begin
      comp_pixdata = cfg_backdrop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACTIVE;
      x            <= '0;
      count        <= 2'd0;
      out_pixdata  <= '0;
      out_x        <= '0;
      tail_pixdata <= '0;
      tail_x       <= '0;
    end else if (flush) begin
      state <= ACTIVE;
      x     <= '0;
      count <= 2'd0;
    end else begin
      if (fire) begin
        if (x == cfg_last_x) begin
          state <= DONE;
        end else begin
          x <= x + {{(W_COORD-1){1'b0}}, 1'b1};
        end
      end
      case ({fire, pop})
        2'b10: begin
          if (count == 2'd0) begin
            out_pixdata <= comp_pixdata;
            out_x       <= x;
            count       <= 2'd1;
          end else begin
            tail_pixdata <= comp_pixdata;
            tail_x       <= x;
            count        <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            out_pixdata <= tail_pixdata;
            out_x       <= tail_x;
          end
          count <= count - 2'd1;
        end
        // Simultaneous push/pop only happens at count 1: replace the head.
        2'b11: begin
          out_pixdata <= comp_pixdata;
          out_x       <= x;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscboy_ppu_blender.sv
// Directed self-checking bench for riscboy_ppu_blender.
module tb_riscboy_ppu_blender;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en_layer;
  logic        flush;
  logic        in0_vld, in0_rdy, in0_alpha;
  logic [14:0] in0_pixdata;
  logic        in1_vld, in1_rdy, in1_alpha;
  logic [14:0] in1_pixdata;
  logic [14:0] cfg_backdrop;
  logic [11:0] cfg_last_x;
  logic        out_vld, out_rdy;
  logic [14:0] out_pixdata;
  logic [11:0] out_x;
  logic        line_done;

  int checks = 0;
  int errors = 0;

  riscboy_ppu_blender #(.W_PIXDATA(15), .W_COORD(12)) dut (
    .clk(clk), .rst(rst), .en_layer(en_layer), .flush(flush),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy), .in0_alpha(in0_alpha), .in0_pixdata(in0_pixdata),
    .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_alpha(in1_alpha), .in1_pixdata(in1_pixdata),
    .cfg_backdrop(cfg_backdrop), .cfg_last_x(cfg_last_x),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pixdata(out_pixdata), .out_x(out_x),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Sample every cycle, then advance; expects x = 0..last in order, one per clock.
  task automatic drain_line(input string tag, input logic [14:0] pix, input int last, input int budget);
    int got = 0;
    int bad = 0;
    int ld = 0;
    int first_c = -1;
    int last_c = -1;
    for (int c = 0; c < budget; c++) begin
      if (line_done) begin
        ld++;
        if (!(out_vld && out_rdy) || out_x != last[11:0]) bad++;
      end
      if ((!en_layer[0] && in0_rdy) || (!en_layer[1] && in1_rdy)) bad++;
      if (out_vld && out_rdy) begin
        if (out_x != got[11:0] || out_pixdata != pix) bad++;
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      step();
    end
    check_eq({tag, "_count"}, got, last + 1);
    check_eq({tag, "_errs"}, bad, 0);
    check_eq({tag, "_line_done"}, ld, 1);
    check_eq({tag, "_rate"}, last_c - first_c, last);
    check_eq({tag, "_done_rdy"}, {30'd0, in1_rdy, in0_rdy}, 32'd0);
    check_eq({tag, "_done_vld"}, {31'd0, out_vld}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; en_layer = 2'b11;
    in0_vld = 1'b1; in0_alpha = 1'b1; in0_pixdata = 15'h1234;
    in1_vld = 1'b1; in1_alpha = 1'b1; in1_pixdata = 15'h0555;
    cfg_backdrop = 15'h7C00; cfg_last_x = 12'd63; out_rdy = 1'b1;

    // Reset state
    step(); step();
    check_eq("rst_rdy", {30'd0, in1_rdy, in0_rdy}, 32'd0);
    check_eq("rst_vld", {31'd0, out_vld}, 32'd0);
    check_eq("rst_pix", {17'd0, out_pixdata}, 32'd0);
    check_eq("rst_x", {20'd0, out_x}, 32'd0);
    check_eq("rst_ld", {31'd0, line_done}, 32'd0);
    rst = 1'b0;

    // Layer 0 opaque wins, full 64-pixel line
    drain_line("l0", 15'h1234, 63, 100);

    // Layer 0 transparent -> layer 1
    in0_alpha = 1'b0; cfg_last_x = 12'd3;
    do_flush();
    drain_line("l1", 15'h0555, 3, 12);

    // Both transparent -> backdrop
    in1_alpha = 1'b0;
    do_flush();
    drain_line("bd", 15'h7C00, 3, 12);

    // No layers enabled: backdrop stream with no input valids
    en_layer = 2'b00; in0_vld = 1'b0; in1_vld = 1'b0;
    do_flush();
    drain_line("en00", 15'h7C00, 3, 12);

    // Layer 0 disabled: its opaque pixel is ignored
    en_layer = 2'b10; in0_alpha = 1'b1; in1_vld = 1'b1; in1_alpha = 1'b1;
    do_flush();
    drain_line("en10", 15'h0555, 3, 12);

    // Backpressure: two pixels buffered, nothing lost
    en_layer = 2'b11; in0_vld = 1'b1; cfg_last_x = 12'd63; out_rdy = 1'b0;
    do_flush();
    repeat (10) step();
    check_eq("bp_vld", {31'd0, out_vld}, 32'd1);
    check_eq("bp_rdy", {30'd0, in1_rdy, in0_rdy}, 32'd0);
    check_eq("bp_head_x", {20'd0, out_x}, 32'd0);
    out_rdy = 1'b1;
    drain_line("bp", 15'h1234, 63, 100);

    // Flush with full FIFO
    cfg_last_x = 12'd7; out_rdy = 1'b0;
    do_flush();
    repeat (3) step();
    check_eq("fl_full_vld", {31'd0, out_vld}, 32'd1);
    do_flush();
    check_eq("fl_vld", {31'd0, out_vld}, 32'd0);
    out_rdy = 1'b1;
    drain_line("fl", 15'h1234, 7, 20);

    // Transfer of the last pixel in the flush cycle still pulses line_done
    cfg_last_x = 12'd0; out_rdy = 1'b0;
    do_flush();
    step(); step();
    check_eq("flld_x", {20'd0, out_x}, 32'd0);
    out_rdy = 1'b1; flush = 1'b1;
    #1;
    check_eq("flld_pulse", {31'd0, line_done}, 32'd1);
    step();
    flush = 1'b0;
    check_eq("flld_vld", {31'd0, out_vld}, 32'd0);

    // Reset mid-line with the FIFO full, flush asserted as well
    cfg_last_x = 12'd63;
    repeat (20) step();
    out_rdy = 1'b0;
    repeat (4) step();
    check_eq("mid_vld", {31'd0, out_vld}, 32'd1);
    check_eq("mid_x", {20'd0, out_x}, 32'd19);
    rst = 1'b1; flush = 1'b1; out_rdy = 1'b1;
    #1;
    check_eq("mid_rst_rdy", {30'd0, in1_rdy, in0_rdy}, 32'd0);
    check_eq("mid_rst_ld", {31'd0, line_done}, 32'd0);
    step();
    check_eq("mid_rst_vld", {31'd0, out_vld}, 32'd0);
    check_eq("mid_rst_pix", {17'd0, out_pixdata}, 32'd0);
    check_eq("mid_rst_x", {20'd0, out_x}, 32'd0);
    rst = 1'b0; flush = 1'b0; cfg_last_x = 12'd7;
    drain_line("post_rst", 15'h1234, 7, 20);

    // All-ones last x: full 4096-pixel line
    cfg_last_x = 12'hFFF;
    do_flush();
    drain_line("wrap", 15'h1234, 4095, 4110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
